// File: rtl/rv32i_pkg.sv
// Shared RV32I core definitions: fetch FSM states, reset/NOP constants and
// small PC helpers used by the fetch stage.
package rv32i_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        CAPTURE = 2'd1,
        VALID   = 2'd2,
        HALT    = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] IMEM_BASE = 32'h0000_1000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    // Sequential successor; wraps modulo 2^32 by construction.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

    // Word-align a jump/branch target by clearing the byte-offset bits.
    function automatic logic [31:0] pc_align(input logic [31:0] target);
        return target & ~32'd3;
    endfunction

    function automatic logic pc_misaligned(input logic [31:0] target);
        return |target[1:0];
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage of the multicycle RV32I core: PC, instruction
// register and valid/ready hand-off to decode. Optional FETCH_MISALIGN_CHECK_EN
// halts on misaligned redirects instead of silently aligning them.
module instr_fetch
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IMEM_BASE
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_data_out,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] fetch_count,
    output logic        misalign_err
);

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next;
    logic [31:0]  instr_q;
    logic [31:0]  instr_pc_q;
    logic [31:0]  fetch_count_q;
    logic         capture;
    logic         accept;
    logic         halt_set;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // Redirect overrides the sequential update and discards any in-flight read.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        capture    = 1'b0;
        accept     = 1'b0;
        halt_set   = 1'b0;

        case (state)
            FETCH:   state_next = CAPTURE;
            CAPTURE: begin
                capture    = 1'b1;
                state_next = VALID;
            end
            VALID: begin
                if (instr_ready) begin
                    accept     = 1'b1;
                    pc_next    = pc_inc(pc);
                    state_next = FETCH;
                end
            end
            default: state_next = HALT;
        endcase

        if (redirect_valid && state != HALT) begin
            capture = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            if (pc_misaligned(redirect_pc)) begin
                halt_set   = 1'b1;
                state_next = HALT;
            end else begin
                pc_next    = redirect_pc;
                state_next = FETCH;
            end
`else
            pc_next    = pc_align(redirect_pc);
            state_next = FETCH;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q    <= NOP_INSTR;
            instr_pc_q <= RESET_PC;
        end else if (capture) begin
            instr_q    <= imem_data_out;
            instr_pc_q <= pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count_q <= '0;
        end else if (accept) begin
            fetch_count_q <= fetch_count_q + 32'd1;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else if (halt_set) begin
            misalign_q <= 1'b1;
        end
    end

    assign misalign_err = misalign_q;
`else
    logic unused_halt;
    assign unused_halt  = halt_set;
    assign misalign_err = 1'b0;
`endif

    assign imem_address   = pc;
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign instr_pc_plus4 = pc_inc(instr_pc_q);
    assign instr_valid    = (state == VALID);
    assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a synchronous-read instruction memory
// model; misalign behaviour follows FETCH_MISALIGN_CHECK_EN when defined.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_address;
    logic [31:0] imem_data_out;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_count;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    instr_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .imem_address   (imem_address),
        .imem_data_out  (imem_data_out),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc_plus4 (instr_pc_plus4),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_count    (fetch_count),
        .misalign_err   (misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0000_1000) ? 32'h0050_0093 : (a ^ 32'hDEAD_0000);
    endfunction

    always @(posedge clk) imem_data_out <= mem_word(imem_address);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        step(); step();
        chk("rst_imem_address", imem_address, 32'h0000_1000);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_instr_pc", instr_pc, 32'h0000_1000);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
        reset = 1'b0;
        step();
        chk("first_capture_valid", {31'd0, instr_valid}, 32'd0);
        step();
        chk("first_valid", {31'd0, instr_valid}, 32'd1);
        chk("first_instr", instr, 32'h0050_0093);
        chk("first_instr_pc", instr_pc, 32'h0000_1000);
        chk("first_plus4", instr_pc_plus4, 32'h0000_1004);
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_instr", instr, 32'h0050_0093);
            chk("stall_instr_pc", instr_pc, 32'h0000_1000);
            chk("stall_count", fetch_count, 32'd0);
            chk("stall_imem", imem_address, 32'h0000_1000);
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk("accept_count", fetch_count, 32'd1);
        chk("accept_imem", imem_address, 32'h0000_1004);
        chk("accept_valid", {31'd0, instr_valid}, 32'd0);
    endtask

    task automatic test_redirect_capture();
        step();  // now in CAPTURE with 0x1004 in flight
        redirect_valid = 1'b1; redirect_pc = 32'h0000_1040;
        step();
        redirect_valid = 1'b0;
        chk("rc_imem", imem_address, 32'h0000_1040);
        chk("rc_instr_kept", instr, 32'h0050_0093);
        chk("rc_valid0", {31'd0, instr_valid}, 32'd0);
        step();
        chk("rc_valid1", {31'd0, instr_valid}, 32'd0);
        step();
        chk("rc_valid2", {31'd0, instr_valid}, 32'd1);
        chk("rc_instr_pc", instr_pc, 32'h0000_1040);
        chk("rc_instr", instr, mem_word(32'h0000_1040));
        chk("rc_count", fetch_count, 32'd1);
    endtask

    task automatic test_redirect_handshake();
        instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_1080;
        step();
        instr_ready = 1'b0; redirect_valid = 1'b0;
        chk("rh_count", fetch_count, 32'd2);
        chk("rh_imem", imem_address, 32'h0000_1080);
        step(); step();
        chk("rh_valid", {31'd0, instr_valid}, 32'd1);
        chk("rh_instr_pc", instr_pc, 32'h0000_1080);
        chk("rh_instr", instr, mem_word(32'h0000_1080));
    endtask

    task automatic test_misalign();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_1042;
        step();
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("ma_err", {31'd0, misalign_err}, 32'd1);
        chk("ma_valid", {31'd0, instr_valid}, 32'd0);
        instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_1100;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("ma_halt_valid", {31'd0, instr_valid}, 32'd0);
            chk("ma_halt_err", {31'd0, misalign_err}, 32'd1);
            chk("ma_halt_count", fetch_count, 32'd2);
        end
        instr_ready = 1'b0; redirect_valid = 1'b0;
`else
        chk("ma_imem", imem_address, 32'h0000_1040);
        chk("ma_err", {31'd0, misalign_err}, 32'd0);
        step(); step();
        chk("ma_valid", {31'd0, instr_valid}, 32'd1);
        chk("ma_instr_pc", instr_pc, 32'h0000_1040);
`endif
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        step();
        reset = 1'b0;
        instr_ready = 1'b1;
        step(); step(); step();   // CAPTURE, VALID, handshake -> FETCH
        chk("rm_pre_count", fetch_count, 32'd1);
        step();                   // CAPTURE of 0x1004
        instr_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rm_instr", instr, 32'h0000_0013);
        chk("rm_valid", {31'd0, instr_valid}, 32'd0);
        chk("rm_count", fetch_count, 32'd0);
        chk("rm_imem", imem_address, 32'h0000_1000);
        step();
        reset = 1'b0;
        step(); step();
        chk("rm_after_valid", {31'd0, instr_valid}, 32'd1);
        chk("rm_after_pc", instr_pc, 32'h0000_1000);
        chk("rm_after_instr", instr, 32'h0050_0093);
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        step(); step();
        chk("wr_instr_pc", instr_pc, 32'hFFFF_FFFC);
        chk("wr_plus4", instr_pc_plus4, 32'h0000_0000);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk("wr_imem", imem_address, 32'h0000_0000);
        chk("wr_count", fetch_count, 32'd1);
    endtask

    initial begin
        test_reset();
        test_stall();
        test_redirect_capture();
        test_redirect_handshake();
        test_misalign();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the multicycle RV32I core: owns the program counter, drives the instruction-memory read address, captures the returned word into an instruction register and offers it to decode over a valid/ready handshake. Sits between the memory block's instruction port and the main decode/execute FSM, and accepts PC redirects from execute for branches and jumps.

## Interface
- RESET_PC, 32'h0000_1000, PC loaded on reset (first IMEM word)
- clk  in  1  core clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- imem_address  out  32  read address to memory instruction port; equals pc register
- imem_data_out  in  32  instruction word; valid the cycle after imem_address is presented (synchronous read)
- instr  out  32  captured instruction
- instr_pc  out  32  address instr was fetched from
- instr_pc_plus4  out  32  instr_pc + 4 (link value for jal/jalr)
- instr_valid  out  1  instr/instr_pc held stable while high
- instr_ready  in  1  decode accepts when instr_valid && instr_ready
- redirect_valid  in  1  one-cycle pulse: load redirect_pc as next fetch address
- redirect_pc  in  32  branch/jump target
- fetch_count  out  32  instructions accepted by decode since reset
- misalign_err  out  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- States: FETCH (address on bus), CAPTURE (data returning), VALID (offer to decode), HALT (error stop).
- FETCH -> CAPTURE unconditionally.
- CAPTURE: instr <= imem_data_out, instr_pc <= pc; -> VALID.
- VALID: instr_valid=1; on instr_ready: pc <= pc+4, fetch_count += 1, -> FETCH; else remain, outputs frozen.
- Redirect (any of FETCH/CAPTURE/VALID) has priority over sequential update: pc <= redirect_pc, -> FETCH; in-flight read in FETCH/CAPTURE discarded (instr not updated).
- Redirect coincident with VALID handshake: handshake counts (fetch_count increments), next fetch from redirect_pc, not pc+4.
- HALT: absorbing; instr_valid=0, ignores redirect and ready; exit only via reset.
- Arithmetic: pc+4 and fetch_count wrap modulo 2^32 silently (0xFFFF_FFFC -> 0x0000_0000).
- Reset mid-operation: in-flight read abandoned; all outputs return to reset values same instant.
- Reset values: pc=RESET_PC, state=FETCH, instr=32'h0000_0013 (NOP), instr_pc=RESET_PC, instr_valid=0, fetch_count=0, misalign_err=0. imem_address=RESET_PC.

## Timing
- Reset release -> instr_valid high: 2 rising edges (FETCH, CAPTURE).
- Handshake -> next instr_valid: 3 cycles later (VALID->FETCH->CAPTURE->VALID); peak rate 1 instr / 3 cycles.
- Redirect pulse in cycle N -> imem_address=redirect_pc in N+1, instr_valid in N+3.
- instr_valid depends only on state (registered); no combinational path from instr_ready or redirect_valid to any output.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined: redirect_pc[1:0]!=0 does not redirect; misalign_err <= 1, state -> HALT, instr_valid drops next cycle. Aligned redirects unaffected.
- Undefined: redirect_pc[1:0] forced to 2'b00 before loading pc; misalign_err tied 0; HALT unreachable.

## Structure
- Shared package rv32i_pkg: fetch_state_t enum (FETCH, CAPTURE, VALID, HALT), NOP_INSTR = 32'h0000_0013, IMEM_BASE = 32'h0000_1000 (RESET_PC default).
- Single module instr_fetch, no sub-module; pc/IR/counter are flat registers.

## Test plan
- Reset, IMEM[0x1000]=0x00500093, ready=1 -> instr_valid at edge 2, instr=0x00500093, instr_pc=0x1000, instr_pc_plus4=0x1004; next imem_address=0x1004.
- Hold ready=0 for 5 cycles in VALID -> instr/instr_pc unchanged, fetch_count unchanged, imem_address stays 0x1000; ready=1 -> fetch_count=1.
- Redirect to 0x1040 during CAPTURE -> word from 0x1004 never presented; next instr_pc=0x1040, 3 cycles after pulse.
- Redirect 0x1080 coincident with VALID handshake -> fetch_count increments, next instr_pc=0x1080.
- Redirect 0x1042: with FETCH_MISALIGN_CHECK_EN -> misalign_err=1, instr_valid=0 thereafter until reset; without -> instr_pc=0x1040, misalign_err=0.
- Assert reset during CAPTURE -> instr=0x00000013, instr_valid=0, fetch_count=0 immediately; after release, fetch from 0x1000.
